// File: rtl/trigger_ctrl.sv
// trigger_ctrl: conditions an asynchronous, bouncing trigger input into a clean
// level for register x5. A write to x5 in writeback acknowledges it; an optional
// hold timeout ends it when no acknowledge arrives.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   trigger_raw  asynchronous trigger source, may bounce
//   RegWrite     writeback-stage register write enable (ack snooping)
//   rd           writeback-stage destination register
//   trigger      conditioned trigger level, high while ACTIVE
//   trig_pulse   one-cycle strobe on each ACTIVE entry
//   trig_count   count of accepted triggers, wraps at 256
//   timeout      sticky: last trigger ended by timeout rather than ack
module trigger_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger_raw,
  input  logic       RegWrite,
  input  logic [4:0] rd,
  output logic       trigger,
  output logic       trig_pulse,
  output logic [7:0] trig_count,
  output logic       timeout
);

  localparam int unsigned HoldW = (HOLD_TIMEOUT == 0) ? 1 : $clog2(HOLD_TIMEOUT + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TIMEOUT - 1);
  localparam logic [15:0]      DebLast  = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StActive, StWaitRelease} state_e;

  logic             sync1_q, sync2_q;
  logic             deb_q;
  logic [15:0]      cnt_q;
  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [7:0]       count_q, count_d;
  logic             timeout_q, timeout_d;
  logic             pulse_q, pulse_d;
  logic             trigger_q, trigger_d;
  logic             ack, hold_done;

  // Synchronizer and debouncer. Any sample agreeing with deb_q clears the
  // counter, so only an unbroken run of DEBOUNCE_CYCLES differing samples counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= trigger_raw;
      sync2_q <= sync1_q;
      if (sync2_q == deb_q) begin
        cnt_q <= 16'd0;
      end else if (cnt_q == DebLast) begin
        deb_q <= sync2_q;
        cnt_q <= 16'd0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign ack       = RegWrite && (rd == 5'd5);
  assign hold_done = (HOLD_TIMEOUT != 0) && (hold_q == HoldLast);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    pulse_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (deb_q) begin
          state_d   = StActive;
          hold_d    = '0;
          pulse_d   = 1'b1;
          count_d   = count_q + 8'd1;
          timeout_d = 1'b0;
        end
      end
      StActive: begin
        // Ack takes priority over a coinciding timeout.
        if (ack) begin
          state_d = StWaitRelease;
        end else if (hold_done) begin
          state_d   = StWaitRelease;
          timeout_d = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StWaitRelease: begin
        if (!deb_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    trigger_d = (state_d == StActive);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      count_q   <= 8'd0;
      timeout_q <= 1'b0;
      pulse_q   <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      pulse_q   <= pulse_d;
      trigger_q <= trigger_d;
    end
  end

  assign trigger    = trigger_q;
  assign trig_pulse = pulse_q;
  assign trig_count = count_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/trigger_ctrl.md
TRIGGER_CTRL -- requirements
Module: trigger_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive synchronized-stable cycles needed to accept an input level change (legal range 2..65535).
REQ-002 Parameter: HOLD_TIMEOUT, default 1024, maximum cycles trigger stays high without acknowledge; 0 = no timeout.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: trigger_raw  input  1  external asynchronous, possibly bouncing, trigger source.
REQ-006 Port: RegWrite  input  1  writeback-stage register write enable, used for acknowledge snooping.
REQ-007 Port: rd  input  5  writeback-stage destination register address.
REQ-008 Port: trigger  output  1  conditioned trigger level driving register x5 of the register file.
REQ-009 Port: trig_pulse  output  1  single-cycle strobe on acceptance of a new trigger.
REQ-010 Port: trig_count  output  8  count of accepted triggers.
REQ-011 Port: timeout  output  1  sticky flag: last trigger ended by timeout, not acknowledge.

Function
REQ-012 trigger_raw SHALL pass through a two-flop synchronizer (sync1, sync2); sync2 is the only consumer-visible sample.
REQ-013 Debouncer SHALL hold debounced level deb and counter cnt: sync2==deb -> cnt<=0; sync2!=deb and cnt==DEBOUNCE_CYCLES-1 -> deb<=sync2, cnt<=0; otherwise cnt<=cnt+1.
REQ-014 Any sync2 reversion to deb before the count completes SHALL reset cnt to 0; no partial credit is retained.
REQ-015 FSM states SHALL be IDLE, ACTIVE, WAIT_RELEASE; encoding free.
REQ-016 IDLE -> ACTIVE when deb==1; otherwise remain.
REQ-017 ACTIVE -> WAIT_RELEASE on ack (RegWrite==1 and rd==5'd5), or on timeout (HOLD_TIMEOUT!=0 and hold_cnt==HOLD_TIMEOUT-1).
REQ-018 WAIT_RELEASE -> IDLE when deb==0; a trigger held high SHALL NOT re-trigger.
REQ-019 Ack SHALL be ignored in IDLE and WAIT_RELEASE.
REQ-020 Simultaneous ack and timeout in ACTIVE: ack wins; timeout flag not set.
REQ-021 trigger SHALL be a registered Moore output, 1 exactly when state==ACTIVE.
REQ-022 Latency: trigger_raw high and stable before edge 1 -> trigger high after edge 3+DEBOUNCE_CYCLES (edge 19 at default).
REQ-023 trig_pulse SHALL be 1 for exactly the first cycle of each ACTIVE entry.
REQ-024 trig_count SHALL increment by 1 on each ACTIVE entry, wrapping 255 -> 0.
REQ-025 hold_cnt SHALL clear on ACTIVE entry and increment each ACTIVE cycle, width ceil(log2(HOLD_TIMEOUT+1)), never wrapping.
REQ-026 timeout SHALL set on a timeout exit and clear on the next ACTIVE entry.
REQ-027 Ack exits SHALL take effect on the same edge the condition is sampled; trigger low from the following cycle.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) force sync1, sync2, deb, cnt, hold_cnt to 0, state IDLE, trigger 0, trig_pulse 0, trig_count 0, timeout 0.
REQ-029 Reset mid-ACTIVE SHALL drop trigger without waiting for clk; no ack needed afterwards.
REQ-030 After rst_n deasserts with trigger_raw held high, a full synchronize+debounce SHALL occur before trigger rises (edge 3+DEBOUNCE_CYCLES after release).

Verification
REQ-031 Default params, trigger_raw 0->1 held -> trigger, trig_pulse high after edge 19; trig_pulse low at edge 20; trig_count=1.
REQ-032 trigger_raw high 10 cycles then low (glitch < 16) -> trigger stays 0, trig_count stays 0.
REQ-033 Active trigger, RegWrite=1 rd=5 one cycle -> trigger low next cycle, timeout=0; raw still high -> no retrigger until raw low >=16 cycles then high again.
REQ-034 HOLD_TIMEOUT=4, no ack -> trigger high exactly 4 cycles, timeout=1; RegWrite=1 rd=5 on 4th cycle -> timeout stays 0.
REQ-035 rst_n low during ACTIVE -> trigger 0 without clock edge, trig_count 0; raw held high -> trigger again edge 19 after release.
REQ-036 256 accepted triggers -> trig_count returns to 0; RegWrite=1 rd=6 in ACTIVE -> no exit.
